pa_fmau_wb_ctrl: RTL and testbench

PA_FMAU_WB_CTRL -- requirements
Module: pa_fmau_wb_ctrl

---
 rtl/pa_fmau_wb_ctrl_pkg.sv | 7 +
 rtl/pa_fmau_wb_ctrl_gated_clk_cell.sv | 25 ++
 rtl/pa_fmau_wb_ctrl.sv | 139 +++++++++++++
 tb/tb_pa_fmau_wb_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pa_fmau_wb_ctrl_pkg.sv
// Shared FPU parameters for the FMAU writeback buffer: operand width, flag width
// and result buffer depth.
package pa_fmau_wb_ctrl_pkg;
    localparam int DOUBLE_WIDTH = 64;
    localparam int FFLAGS_WIDTH = 5;
    localparam int WB_DEPTH     = 2;
endpackage

// File: rtl/pa_fmau_wb_ctrl_gated_clk_cell.sv
// Latch-based integrated clock gate: the enable is captured while the clock is low
// so the gated clock never glitches; scan enable forces the clock on.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en;
    logic clk_en_lat;

    assign clk_en = (global_en && (module_en || local_en)) || pad_yy_icg_scan_en;

    always_latch begin
        if (!clk_in) begin
            clk_en_lat = clk_en;
        end
    end

    assign clk_out = clk_in && clk_en_lat;

endmodule

// File: rtl/pa_fmau_wb_ctrl.sv
// FMAU writeback controller: 2-entry in-order result buffer between the EX3/EX4
// result sources and the FPU register-file write port, with sticky flag accumulation.
module pa_fmau_wb_ctrl
    import pa_fmau_wb_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DOUBLE_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    cp0_yy_clk_en,
    input  logic                    cp0_fpu_icg_en,
    input  logic                    pad_yy_icg_scan_en,
    input  logic                    fmau_fpu_ex3_result_vld,
    input  logic [DATA_WIDTH-1:0]   dp_wb_ex3_result,
    input  logic [FFLAGS_WIDTH-1:0] dp_wb_ex3_fflags,
    input  logic                    ex4_inst_vld,
    input  logic [DATA_WIDTH-1:0]   dp_wb_ex4_result,
    input  logic [FFLAGS_WIDTH-1:0] dp_wb_ex4_fflags,
    input  logic                    fpu_fmau_wb_grant,
    input  logic                    cp0_fpu_fflags_clr,
    output logic                    fmau_fpu_wb_vld,
    output logic [DATA_WIDTH-1:0]   fmau_fpu_wb_data,
    output logic [FFLAGS_WIDTH-1:0] fmau_fpu_wb_fflags,
    output logic                    fmau_ctrl_ex3_stall,
    output logic                    fmau_ctrl_ex4_stall,
    output logic [FFLAGS_WIDTH-1:0] fmau_fpu_fflags_acc
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [1:0]              count;
    logic                    wptr;
    logic                    rptr;
    logic [FFLAGS_WIDTH-1:0] fflags_acc;

    logic [DATA_WIDTH-1:0]   entry_data  [2];
    logic [FFLAGS_WIDTH-1:0] entry_flags [2];

    logic                    wb_vld;
    logic                    pop;
    logic [1:0]              free;
    logic                    ex3_stall;
    logic                    ex4_stall;
    logic                    push_ex3;
    logic                    push_ex4;
    logic                    ex3_slot;
    logic [1:0]              count_next;
    logic                    wptr_next;
    logic                    rptr_next;
    logic [FFLAGS_WIDTH-1:0] fflags_acc_next;

    logic                    entry_clk;
    logic                    ctrl_clk;
    logic                    entry_local_en;
    logic                    ctrl_local_en;

    assign wb_vld = (count != 2'd0);
    assign pop    = wb_vld && fpu_fmau_wb_grant;
    assign free   = DEPTH_C - count + {1'b0, pop};

    // EX4 is older, so it claims a free slot before EX3 does.
    assign ex4_stall = ex4_inst_vld && (free == 2'd0);
    assign ex3_stall = fmau_fpu_ex3_result_vld && (free < (2'd1 + {1'b0, ex4_inst_vld}));

    assign push_ex4 = ex4_inst_vld && !ex4_stall;
    assign push_ex3 = fmau_fpu_ex3_result_vld && !ex3_stall;
    assign ex3_slot = wptr ^ push_ex4;

    assign count_next = count + {1'b0, push_ex4} + {1'b0, push_ex3} - {1'b0, pop};
    assign wptr_next  = wptr ^ push_ex4 ^ push_ex3;
    assign rptr_next  = rptr ^ pop;

    always_comb begin
        fflags_acc_next = fflags_acc;
        if (pop) begin
            fflags_acc_next = cp0_fpu_fflags_clr ? entry_flags[rptr]
                                                 : (fflags_acc | entry_flags[rptr]);
        end else if (cp0_fpu_fflags_clr) begin
            fflags_acc_next = '0;
        end
    end

    assign entry_local_en = push_ex4 || push_ex3;
    assign ctrl_local_en  = fmau_fpu_ex3_result_vld || ex4_inst_vld || wb_vld
                         || cp0_fpu_fflags_clr;

    gated_clk_cell u_entry_gclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_fpu_icg_en),
        .local_en           (entry_local_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (entry_clk)
    );

    gated_clk_cell u_ctrl_gclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_fpu_icg_en),
        .local_en           (ctrl_local_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ctrl_clk)
    );

    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            count      <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            fflags_acc <= '0;
        end else begin
            count      <= count_next;
            wptr       <= wptr_next;
            rptr       <= rptr_next;
            fflags_acc <= fflags_acc_next;
        end
    end

    // Entry payload is never observed while count is zero, so it carries no reset.
    always_ff @(posedge entry_clk) begin
        if (push_ex4) begin
            entry_data[wptr]  <= dp_wb_ex4_result;
            entry_flags[wptr] <= dp_wb_ex4_fflags;
        end
        if (push_ex3) begin
            entry_data[ex3_slot]  <= dp_wb_ex3_result;
            entry_flags[ex3_slot] <= dp_wb_ex3_fflags;
        end
    end

    assign fmau_fpu_wb_vld     = wb_vld;
    assign fmau_fpu_wb_data    = entry_data[rptr];
    assign fmau_fpu_wb_fflags  = entry_flags[rptr];
    assign fmau_ctrl_ex3_stall = ex3_stall;
    assign fmau_ctrl_ex4_stall = ex4_stall;
    assign fmau_fpu_fflags_acc = fflags_acc;

endmodule

// File: tb/tb_pa_fmau_wb_ctrl.sv
// Bench for pa_fmau_wb_ctrl: per-cycle vector table with hand-computed outputs,
// then a hand-written reset-during-operation sequence.
module tb_pa_fmau_wb_ctrl;

    localparam int DW = 64;

    localparam logic [DW-1:0] D_R = 64'h3FF0_0000_0000_0000;
    localparam logic [DW-1:0] D_A = 64'h0000_0000_0000_AAAA;
    localparam logic [DW-1:0] D_B = 64'h0000_0000_0000_BBBB;
    localparam logic [DW-1:0] D_C = 64'h0000_0000_0000_CCCC;
    localparam logic [DW-1:0] D_D = 64'h0000_0000_0000_DDDD;
    localparam logic [DW-1:0] D_E = 64'h0000_0000_0000_EEEE;
    localparam logic [DW-1:0] D_F = 64'h0000_0000_0000_FFFF;
    localparam logic [DW-1:0] D_G = 64'h1111_0000_0000_0000;
    localparam logic [DW-1:0] D_H = 64'h2222_0000_0000_0000;
    localparam logic [DW-1:0] D_0 = 64'h0;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          clk_en, icg_en, scan_en;
    logic          ex3_vld;
    logic [DW-1:0] ex3_res;
    logic [4:0]    ex3_ff;
    logic          ex4_vld;
    logic [DW-1:0] ex4_res;
    logic [4:0]    ex4_ff;
    logic          grant;
    logic          clr;
    logic          wb_vld;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_ff;
    logic          ex3_stall, ex4_stall;
    logic [4:0]    acc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pa_fmau_wb_ctrl #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
        .forever_cpuclk          (clk),
        .cpurst_b                (rst_b),
        .cp0_yy_clk_en           (clk_en),
        .cp0_fpu_icg_en          (icg_en),
        .pad_yy_icg_scan_en      (scan_en),
        .fmau_fpu_ex3_result_vld (ex3_vld),
        .dp_wb_ex3_result        (ex3_res),
        .dp_wb_ex3_fflags        (ex3_ff),
        .ex4_inst_vld            (ex4_vld),
        .dp_wb_ex4_result        (ex4_res),
        .dp_wb_ex4_fflags        (ex4_ff),
        .fpu_fmau_wb_grant       (grant),
        .cp0_fpu_fflags_clr      (clr),
        .fmau_fpu_wb_vld         (wb_vld),
        .fmau_fpu_wb_data        (wb_data),
        .fmau_fpu_wb_fflags      (wb_ff),
        .fmau_ctrl_ex3_stall     (ex3_stall),
        .fmau_ctrl_ex4_stall     (ex4_stall),
        .fmau_fpu_fflags_acc     (acc)
    );

    typedef struct packed {
        logic          e3v;
        logic [DW-1:0] e3d;
        logic [4:0]    e3f;
        logic          e4v;
        logic [DW-1:0] e4d;
        logic [4:0]    e4f;
        logic          g;
        logic          c;
        logic          x_wbv;
        logic [DW-1:0] x_data;
        logic [4:0]    x_ff;
        logic          x_s3;
        logic          x_s4;
        logic [4:0]    x_acc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic e3v, input logic [DW-1:0] e3d, input logic [4:0] e3f,
                                input logic e4v, input logic [DW-1:0] e4d, input logic [4:0] e4f,
                                input logic g, input logic c,
                                input logic x_wbv, input logic [DW-1:0] x_data, input logic [4:0] x_ff,
                                input logic x_s3, input logic x_s4, input logic [4:0] x_acc);
        vec_t v;
        v = '{e3v, e3d, e3f, e4v, e4d, e4f, g, c, x_wbv, x_data, x_ff, x_s3, x_s4, x_acc};
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic e3v, input logic [DW-1:0] e3d, input logic [4:0] e3f,
                         input logic e4v, input logic [DW-1:0] e4d, input logic [4:0] e4f,
                         input logic g, input logic c);
        ex3_vld = e3v; ex3_res = e3d; ex3_ff = e3f;
        ex4_vld = e4v; ex4_res = e4d; ex4_ff = e4f;
        grant = g; clr = c;
    endtask

    initial begin
        // One record per cycle: inputs for the cycle, outputs expected in that cycle.
        //               e3v e3d  e3f    e4v e4d  e4f    g  c   wbv data ff     s3 s4 acc
        vecs[0]  = mk(1, D_R, 5'h00, 0, D_0, 5'h00, 1, 0,  0, D_0, 5'h00, 0, 0, 5'h00);
        vecs[1]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_R, 5'h00, 0, 0, 5'h00);
        vecs[2]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  0, D_0, 5'h00, 0, 0, 5'h00);
        vecs[3]  = mk(1, D_B, 5'h10, 1, D_A, 5'h01, 0, 0,  0, D_0, 5'h00, 0, 0, 5'h00);
        vecs[4]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 0, 0,  1, D_A, 5'h01, 0, 0, 5'h00);
        vecs[5]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_A, 5'h01, 0, 0, 5'h00);
        vecs[6]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_B, 5'h10, 0, 0, 5'h01);
        vecs[7]  = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 0, 0,  0, D_0, 5'h00, 0, 0, 5'h11);
        vecs[8]  = mk(1, D_D, 5'h02, 1, D_C, 5'h04, 0, 0,  0, D_0, 5'h00, 0, 0, 5'h11);
        vecs[9]  = mk(1, D_E, 5'h08, 0, D_0, 5'h00, 0, 0,  1, D_C, 5'h04, 1, 0, 5'h11);
        vecs[10] = mk(1, D_E, 5'h08, 0, D_0, 5'h00, 0, 0,  1, D_C, 5'h04, 1, 0, 5'h11);
        vecs[11] = mk(1, D_E, 5'h08, 0, D_0, 5'h00, 1, 1,  1, D_C, 5'h04, 0, 0, 5'h11);
        vecs[12] = mk(1, D_F, 5'h00, 0, D_0, 5'h00, 0, 0,  1, D_D, 5'h02, 1, 0, 5'h04);
        vecs[13] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_D, 5'h02, 0, 0, 5'h04);
        vecs[14] = mk(1, D_H, 5'h01, 1, D_G, 5'h00, 0, 0,  1, D_E, 5'h08, 1, 0, 5'h06);
        vecs[15] = mk(1, D_H, 5'h01, 0, D_0, 5'h00, 1, 0,  1, D_E, 5'h08, 0, 0, 5'h06);
        vecs[16] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_G, 5'h00, 0, 0, 5'h0E);
        vecs[17] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 1, 0,  1, D_H, 5'h01, 0, 0, 5'h0E);
        vecs[18] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 0, 0,  0, D_0, 5'h00, 0, 0, 5'h0F);
        vecs[19] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 0, 1,  0, D_0, 5'h00, 0, 0, 5'h0F);
        vecs[20] = mk(0, D_0, 5'h00, 0, D_0, 5'h00, 0, 0,  0, D_0, 5'h00, 0, 0, 5'h00);

        rst_b = 1'b0; clk_en = 1'b1; icg_en = 1'b1; scan_en = 1'b0;
        drive(0, D_0, 5'h0, 0, D_0, 5'h0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst wb_vld", DW'(wb_vld), DW'(1'b0));
        check("rst ex3_stall", DW'(ex3_stall), DW'(1'b0));
        check("rst ex4_stall", DW'(ex4_stall), DW'(1'b0));
        check("rst acc", DW'(acc), DW'(5'h00));
        rst_b = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].e3v, vecs[i].e3d, vecs[i].e3f, vecs[i].e4v, vecs[i].e4d, vecs[i].e4f,
                  vecs[i].g, vecs[i].c);
            #1;
            check($sformatf("v%0d wb_vld", i), DW'(wb_vld), DW'(vecs[i].x_wbv));
            if (vecs[i].x_wbv) begin
                check($sformatf("v%0d wb_data", i), wb_data, vecs[i].x_data);
                check($sformatf("v%0d wb_fflags", i), DW'(wb_ff), DW'(vecs[i].x_ff));
            end
            check($sformatf("v%0d ex3_stall", i), DW'(ex3_stall), DW'(vecs[i].x_s3));
            check($sformatf("v%0d ex4_stall", i), DW'(ex4_stall), DW'(vecs[i].x_s4));
            check($sformatf("v%0d acc", i), DW'(acc), DW'(vecs[i].x_acc));
        end

        // Fill the buffer with a non-zero accumulator, then reset mid-operation.
        @(negedge clk);
        drive(1, D_B, 5'h01, 1, D_A, 5'h10, 0, 0);
        #1;
        check("seq fill wb_vld", DW'(wb_vld), DW'(1'b0));
        @(negedge clk);
        drive(0, D_0, 5'h0, 0, D_0, 5'h0, 1, 0);
        #1;
        check("seq head A", wb_data, D_A);
        @(negedge clk);
        drive(1, D_C, 5'h00, 0, D_0, 5'h0, 0, 0);
        #1;
        check("seq head B", wb_data, D_B);
        check("seq acc before rst", DW'(acc), DW'(5'h10));
        check("seq ex3 accept", DW'(ex3_stall), DW'(1'b0));
        @(negedge clk);
        drive(1, D_D, 5'h00, 1, D_E, 5'h00, 0, 0);
        #1;
        check("seq full ex3_stall", DW'(ex3_stall), DW'(1'b1));
        check("seq full ex4_stall", DW'(ex4_stall), DW'(1'b1));
        check("seq full wb_vld", DW'(wb_vld), DW'(1'b1));
        #1 rst_b = 1'b0;
        #1;
        check("async rst wb_vld", DW'(wb_vld), DW'(1'b0));
        check("async rst acc", DW'(acc), DW'(5'h00));
        check("async rst ex3_stall", DW'(ex3_stall), DW'(1'b0));
        check("async rst ex4_stall", DW'(ex4_stall), DW'(1'b0));
        @(negedge clk);
        drive(0, D_0, 5'h0, 0, D_0, 5'h0, 1, 0);
        rst_b = 1'b1;
        #1;
        check("post rst wb_vld", DW'(wb_vld), DW'(1'b0));
        @(negedge clk);
        drive(1, D_R, 5'h02, 0, D_0, 5'h0, 1, 0);
        #1;
        check("post rst idle wb_vld", DW'(wb_vld), DW'(1'b0));
        @(negedge clk);
        drive(0, D_0, 5'h0, 0, D_0, 5'h0, 1, 0);
        #1;
        check("post rst wb_vld 1", DW'(wb_vld), DW'(1'b1));
        check("post rst wb_data", wb_data, D_R);
        check("post rst wb_fflags", DW'(wb_ff), DW'(5'h02));
        @(negedge clk);
        #1;
        check("post rst drained", DW'(wb_vld), DW'(1'b0));
        check("post rst acc", DW'(acc), DW'(5'h02));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
